mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of SRAM access cycles per transaction (legal 1..15).
REQ-002 SHALL have port Clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cpu_req / cpu_we  input  1 each  CPU access request / write (1) vs read (0).
REQ-005 SHALL have ports cpu_addr, cpu_wdata  input  16 each  CPU address and write data.
REQ-006 SHALL have ports cpu_rdata  output  16, cpu_done  output  1  CPU read data and completion pulse.
REQ-007 SHALL have ports dbg_req, dbg_we  input  1; dbg_addr, dbg_wdata  input  16; dbg_rdata  output  16; dbg_done  output  1, the same set for the debug/loader requester.
REQ-008 SHALL have ports Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  active-low SRAM strobes.
REQ-009 SHALL have ports Mem_ADDR  output  20  SRAM address; Mem_Dout  output  16  write data; Mem_Drive  output  1  tristate drive enable; Mem_Din  input  16  SRAM read data.
REQ-010 SHALL have ports busy  output  1  transaction in progress; grant  output  1  current or last owner (0 = CPU, 1 = debug).

Function
REQ-011 SHALL implement the states IDLE, ACCESS and DONE.
REQ-012 IDLE: when either req is high, SHALL select an owner, latch its we/addr/wdata, clear the cycle counter and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-013 Arbitration: a single requester SHALL be granted; with both requesting, the requester not granted last SHALL win (round-robin).
REQ-014 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a counter of width ceil(log2(WAIT_CYCLES+1)), then go to DONE.
REQ-015 During ACCESS: Mem_CE/UB/LB SHALL be 0 and Mem_ADDR = {4'h0, latched addr}.
REQ-016 During ACCESS, reads: Mem_OE=0, Mem_WE=1, Mem_Drive=0.
REQ-017 During ACCESS, writes: Mem_WE=0, Mem_OE=1, Mem_Drive=1, Mem_Dout = latched wdata.
REQ-018 Outside ACCESS: all strobes SHALL be 1 and Mem_Drive=0.
REQ-019 On a read, Mem_Din SHALL be registered into the owner's rdata at the last ACCESS edge; the other requester's rdata SHALL hold.
REQ-020 DONE SHALL last one cycle, assert only the owner's done (read data valid), and return to IDLE.
REQ-021 Latency: req sampled at edge k -> done high in cycle k+WAIT_CYCLES+1; back-to-back transactions spaced WAIT_CYCLES+2 cycles.
REQ-022 Handshake: req, we, addr and wdata SHALL be held until done; the requester drops req the cycle after done; req in ACCESS/DONE SHALL be ignored, and req still high in IDLE SHALL start a new transaction.
REQ-023 busy SHALL be 1 in ACCESS and DONE, else 0.
REQ-024 grant SHALL update only on leaving IDLE.
REQ-025 An out-of-range state SHALL recover to IDLE with all strobes deasserted.

Reset
REQ-026 Reset SHALL asynchronously force IDLE and clear the counter, latched fields and rdata.
REQ-027 Reset SHALL force busy=0, done=0 for both requesters, Mem_* strobes=1, Mem_Drive=0, Mem_ADDR=0, Mem_Dout=0, and grant=1 (so CPU wins the first tie).
REQ-028 Reset mid-ACCESS SHALL deassert Mem_WE/OE immediately, issue no done, and abandon the transaction.

Structure
REQ-029 The state enum, the requester-ID enum (CPU, DBG) and the WAIT_CYCLES bounds SHALL live in shared package MEM_ARB_PKG.
REQ-030 The round-robin select SHALL be sub-module mem_arb_rr (inputs: two reqs, last grant; output: winner).

Verification
REQ-031 CPU read only, addr 16'h0012, Mem_Din=16'hBEEF, WAIT_CYCLES=2 -> Mem_OE=0 for exactly 2 cycles, cpu_done pulse at cycle 3, cpu_rdata=16'hBEEF, dbg_rdata unchanged.
REQ-032 Debug write only, addr 16'h0100, wdata 16'h1234 -> Mem_WE=0 and Mem_Drive=1 for 2 cycles, Mem_ADDR=20'h00100, Mem_Dout=16'h1234, dbg_done pulse.
REQ-033 Both requesting continuously after reset -> grants CPU, DBG, CPU, DBG, and each done is 4 cycles apart.
REQ-034 CPU changes cpu_addr during ACCESS -> Mem_ADDR keeps the latched value.
REQ-035 Reset asserted in the 1st ACCESS cycle of a write -> strobes go to 1 without waiting for a clock edge, no done pulse, and the next request completes normally.
REQ-036 WAIT_CYCLES=1 and =15 -> ACCESS lasts 1 / 15 cycles and the done timing matches REQ-021.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and limits for the two-port SRAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter controller states; the fourth encoding is unused and recovers to idle
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Requester identity, also the encoding of the grant output
    typedef enum logic {
        ID_CPU = 1'b0,
        ID_DBG = 1'b1
    } req_id_t;

    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 15;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Requester handshakes plus SRAM pin bundle of the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;

    // CPU requester
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_done;

    // Debug / loader requester
    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic [15:0] dbg_rdata;
    logic        dbg_done;

    // SRAM side, strobes active-low
    logic        Mem_CE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [19:0] Mem_ADDR;
    logic [15:0] Mem_Dout;
    logic        Mem_Drive;
    logic [15:0] Mem_Din;

    // Status
    logic        busy;
    logic        grant;

    // Environment side: requesters and the SRAM data return
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_done,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        input  Mem_ADDR, Mem_Dout, Mem_Drive,
        output Mem_Din,
        input  busy, grant
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_done,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        output Mem_ADDR, Mem_Dout, Mem_Drive,
        input  Mem_Din,
        output busy, grant
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_rr
//  Description : Two-way round-robin select; a tie goes to the requester
//                that did not own the previous transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  wire logic    cpu_req,
    input  wire logic    dbg_req,
    input  req_id_t      last_grant,
    output req_id_t      winner
);

    // Pick the lone requester, or alternate on a tie
    always_comb begin
        winner = ID_CPU;
        if (cpu_req && dbg_req) begin
            winner = (last_grant == ID_CPU) ? ID_DBG : ID_CPU;
        end else if (dbg_req) begin
            winner = ID_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates CPU and debug requesters onto one asynchronous
//                SRAM; each transaction is WAIT_CYCLES access cycles plus a
//                one-cycle completion pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  wire logic    Clk,
    input  wire logic    Reset,
    mem_arbiter_if.slave bus
);

    localparam int              CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
            $error("mem_arbiter: WAIT_CYCLES out of range");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    req_id_t          owner;
    req_id_t          winner;

    logic             lat_we;
    logic [15:0]      lat_addr;
    logic [15:0]      lat_wdata;

    logic             sel_we;
    logic [15:0]      sel_addr;
    logic [15:0]      sel_wdata;

    logic [15:0]      cpu_rdata_q;
    logic [15:0]      dbg_rdata_q;
    logic             cpu_done_q;
    logic             dbg_done_q;
    logic             busy_q;
    logic             ce_n;
    logic             oe_n;
    logic             we_n;
    logic             drive;

    mem_arb_rr u_rr (
        .cpu_req    (bus.cpu_req),
        .dbg_req    (bus.dbg_req),
        .last_grant (owner),
        .winner     (winner)
    );

    // Route the winning requester's command fields to the latch inputs
    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (winner == ID_DBG) begin
            sel_we    = bus.dbg_we;
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
        end
    end

    // Controller: state, access counter, latched command and registered strobes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            owner       <= ID_DBG;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            ce_n        <= 1'b1;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            drive       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_req || bus.dbg_req) begin
                        state     <= ST_ACCESS;
                        cnt       <= '0;
                        owner     <= winner;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        busy_q    <= 1'b1;
                        ce_n      <= 1'b0;
                        oe_n      <= sel_we;
                        we_n      <= ~sel_we;
                        drive     <= sel_we;
                    end
                end

                ST_ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                        ce_n  <= 1'b1;
                        oe_n  <= 1'b1;
                        we_n  <= 1'b1;
                        drive <= 1'b0;
                        // Data is captured on the final access edge, while OE is still low
                        if (!lat_we) begin
                            if (owner == ID_CPU) begin
                                cpu_rdata_q <= bus.Mem_Din;
                            end else begin
                                dbg_rdata_q <= bus.Mem_Din;
                            end
                        end
                        if (owner == ID_CPU) begin
                            cpu_done_q <= 1'b1;
                        end else begin
                            dbg_done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state      <= ST_IDLE;
                    cpu_done_q <= 1'b0;
                    dbg_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                end

                default: begin
                    state      <= ST_IDLE;
                    cpu_done_q <= 1'b0;
                    dbg_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    ce_n       <= 1'b1;
                    oe_n       <= 1'b1;
                    we_n       <= 1'b1;
                    drive      <= 1'b0;
                end
            endcase
        end
    end

    // Byte lanes are always enabled together with chip enable
    assign bus.Mem_CE    = ce_n;
    assign bus.Mem_UB    = ce_n;
    assign bus.Mem_LB    = ce_n;
    assign bus.Mem_OE    = oe_n;
    assign bus.Mem_WE    = we_n;
    assign bus.Mem_Drive = drive;
    assign bus.Mem_ADDR  = {4'h0, lat_addr};
    assign bus.Mem_Dout  = lat_wdata;

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dbg_done  = dbg_done_q;
    assign bus.busy      = busy_q;
    assign bus.grant     = owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter at
//                WAIT_CYCLES = 2, 1 and 15.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   sel    = 2;

    logic mon_oe;
    logic mon_we;
    logic mon_done;

    int oe_low;
    int we_low;
    int done_at;
    int n;
    int done_cyc [4];
    int done_who [4];

    always #5 clk = ~clk;

    mem_arbiter_if b2  ();
    mem_arbiter_if b1  ();
    mem_arbiter_if b15 ();

    mem_arbiter #(.WAIT_CYCLES(2))  dut2  (.Clk(clk), .Reset(rst), .bus(b2));
    mem_arbiter #(.WAIT_CYCLES(1))  dut1  (.Clk(clk), .Reset(rst), .bus(b1));
    mem_arbiter #(.WAIT_CYCLES(15)) dut15 (.Clk(clk), .Reset(rst), .bus(b15));

    // Strobe/done monitor of the instance currently under measurement
    always_comb begin
        mon_oe   = b2.Mem_OE;
        mon_we   = b2.Mem_WE;
        mon_done = b2.cpu_done | b2.dbg_done;
        if (sel == 1) begin
            mon_oe   = b1.Mem_OE;
            mon_we   = b1.Mem_WE;
            mon_done = b1.cpu_done | b1.dbg_done;
        end else if (sel == 15) begin
            mon_oe   = b15.Mem_OE;
            mon_we   = b15.Mem_WE;
            mon_done = b15.cpu_done | b15.dbg_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count low strobe cycles until a done pulse; done_at is the cycle index
    // after the request-sampling edge (1 = first cycle after it)
    task automatic measure(output int oe_cnt, output int we_cnt, output int done_idx);
        oe_cnt   = 0;
        we_cnt   = 0;
        done_idx = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!mon_oe) oe_cnt++;
            if (!mon_we) we_cnt++;
            if (mon_done) begin
                done_idx = i;
                break;
            end
        end
    endtask

    initial begin
        b2.cpu_req  = 0; b2.cpu_we  = 0; b2.cpu_addr  = 0; b2.cpu_wdata  = 0;
        b2.dbg_req  = 0; b2.dbg_we  = 0; b2.dbg_addr  = 0; b2.dbg_wdata  = 0; b2.Mem_Din  = 0;
        b1.cpu_req  = 0; b1.cpu_we  = 0; b1.cpu_addr  = 0; b1.cpu_wdata  = 0;
        b1.dbg_req  = 0; b1.dbg_we  = 0; b1.dbg_addr  = 0; b1.dbg_wdata  = 0; b1.Mem_Din  = 0;
        b15.cpu_req = 0; b15.cpu_we = 0; b15.cpu_addr = 0; b15.cpu_wdata = 0;
        b15.dbg_req = 0; b15.dbg_we = 0; b15.dbg_addr = 0; b15.dbg_wdata = 0; b15.Mem_Din = 0;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_busy",  b2.busy, 0);
        check("rst_strb",  {b2.Mem_CE, b2.Mem_UB, b2.Mem_LB, b2.Mem_OE, b2.Mem_WE}, 5'h1F);
        check("rst_drive", b2.Mem_Drive, 0);
        check("rst_addr",  b2.Mem_ADDR, 0);
        check("rst_dout",  b2.Mem_Dout, 0);
        check("rst_grant", b2.grant, 1);
        check("rst_done",  {b2.cpu_done, b2.dbg_done}, 0);
        check("rst_rdata", {b2.cpu_rdata, b2.dbg_rdata}, 0);
        rst = 1'b0;

        // CPU read at 0x0012, SRAM returns 0xBEEF
        b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 16'h0012; b2.Mem_Din = 16'hBEEF;
        tick();
        check("rd_c1_strb",  {b2.Mem_CE, b2.Mem_UB, b2.Mem_LB, b2.Mem_OE, b2.Mem_WE}, 5'b00001);
        check("rd_c1_drive", b2.Mem_Drive, 0);
        check("rd_c1_addr",  b2.Mem_ADDR, 20'h00012);
        check("rd_c1_busy",  b2.busy, 1);
        check("rd_c1_grant", b2.grant, 0);
        check("rd_c1_done",  b2.cpu_done, 0);
        b2.cpu_addr = 16'hFFFF;                     // changed mid-access, must be ignored
        tick();
        check("rd_c2_oe",    b2.Mem_OE, 0);
        check("rd_c2_addr",  b2.Mem_ADDR, 20'h00012);
        tick();
        check("rd_c3_oe",    b2.Mem_OE, 1);
        check("rd_c3_done",  {b2.cpu_done, b2.dbg_done}, 2'b10);
        check("rd_c3_rdata", b2.cpu_rdata, 16'hBEEF);
        check("rd_c3_dbgrd", b2.dbg_rdata, 16'h0000);
        check("rd_c3_busy",  b2.busy, 1);
        b2.cpu_req = 0; b2.Mem_Din = 16'h0000;
        tick();
        check("rd_c4_done",  b2.cpu_done, 0);
        check("rd_c4_busy",  b2.busy, 0);

        // Debug write 0x1234 to 0x0100
        b2.dbg_req = 1; b2.dbg_we = 1; b2.dbg_addr = 16'h0100; b2.dbg_wdata = 16'h1234;
        tick();
        check("wr_c1_strb",  {b2.Mem_CE, b2.Mem_OE, b2.Mem_WE, b2.Mem_Drive}, 4'b0101);
        check("wr_c1_addr",  b2.Mem_ADDR, 20'h00100);
        check("wr_c1_dout",  b2.Mem_Dout, 16'h1234);
        check("wr_c1_grant", b2.grant, 1);
        tick();
        check("wr_c2_strb",  {b2.Mem_WE, b2.Mem_Drive}, 2'b01);
        tick();
        check("wr_c3_strb",  {b2.Mem_CE, b2.Mem_OE, b2.Mem_WE, b2.Mem_Drive}, 4'b1110);
        check("wr_c3_done",  {b2.cpu_done, b2.dbg_done}, 2'b01);
        check("wr_c3_cpurd", b2.cpu_rdata, 16'hBEEF);
        b2.dbg_req = 0; b2.dbg_we = 0;
        tick();
        check("wr_c4_done",  b2.dbg_done, 0);

        // Both requesting continuously after reset: CPU, DBG, CPU, DBG, 4 cycles apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 16'h0001;
        b2.dbg_req = 1; b2.dbg_we = 0; b2.dbg_addr = 16'h0002; b2.Mem_Din = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            done_cyc[i] = -1;
            done_who[i] = -1;
        end
        n = 0;
        for (int i = 1; i <= 40 && n < 4; i++) begin
            tick();
            if (b2.cpu_done || b2.dbg_done) begin
                done_cyc[n] = i;
                done_who[n] = b2.dbg_done ? 1 : 0;
                n++;
            end
        end
        b2.cpu_req = 0; b2.dbg_req = 0;
        check("rr_count", n, 4);
        check("rr_first", done_cyc[0], 3);
        check("rr_order", {done_who[0][3:0], done_who[1][3:0], done_who[2][3:0], done_who[3][3:0]}, 16'h0101);
        for (int i = 1; i < 4; i++) begin
            check("rr_gap", done_cyc[i] - done_cyc[i-1], 4);
        end
        tick();
        tick();
        check("rr_idle", b2.busy, 0);

        // Reset in the first access cycle of a write
        b2.cpu_req = 1; b2.cpu_we = 1; b2.cpu_addr = 16'h0200; b2.cpu_wdata = 16'hABCD;
        tick();
        check("ar_pre_we", b2.Mem_WE, 0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_strb",  {b2.Mem_CE, b2.Mem_UB, b2.Mem_LB, b2.Mem_OE, b2.Mem_WE, b2.Mem_Drive}, 6'b111110);
        check("ar_busy",  b2.busy, 0);
        b2.cpu_req = 0; b2.cpu_we = 0;
        tick();
        rst = 1'b0;
        tick();
        check("ar_nodone", {b2.cpu_done, b2.dbg_done, b2.busy}, 3'b000);
        tick();
        check("ar_nodone2", {b2.cpu_done, b2.dbg_done}, 2'b00);

        // Next request after the abandoned one completes normally
        sel = 2;
        b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 16'h0003; b2.Mem_Din = 16'h0C0C;
        measure(oe_low, we_low, done_at);
        check("ar_next_oe",   oe_low, 2);
        check("ar_next_done", done_at, 3);
        check("ar_next_rd",   b2.cpu_rdata, 16'h0C0C);
        b2.cpu_req = 0;
        tick();

        // WAIT_CYCLES = 1: one access cycle, done one cycle later, 3-cycle spacing
        sel = 1;
        b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0044; b1.Mem_Din = 16'h1111;
        measure(oe_low, we_low, done_at);
        check("w1_oe",   oe_low, 1);
        check("w1_done", done_at, 2);
        check("w1_rd",   b1.cpu_rdata, 16'h1111);
        b1.Mem_Din = 16'h2222;
        measure(oe_low, we_low, done_at);
        check("w1_b2b_oe",   oe_low, 1);
        check("w1_b2b_done", done_at, 3);
        check("w1_b2b_rd",   b1.cpu_rdata, 16'h2222);
        b1.cpu_req = 0;
        tick();

        // WAIT_CYCLES = 15: debug write holds WE low 15 cycles, done at cycle 16
        sel = 15;
        b15.dbg_req = 1; b15.dbg_we = 1; b15.dbg_addr = 16'h0777; b15.dbg_wdata = 16'h5A5A;
        measure(oe_low, we_low, done_at);
        check("w15_we",   we_low, 15);
        check("w15_oe",   oe_low, 0);
        check("w15_done", done_at, 16);
        check("w15_who",  {b15.cpu_done, b15.dbg_done}, 2'b01);
        b15.dbg_req = 0; b15.dbg_we = 0;
        tick();
        check("w15_idle", b15.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
